// File: rtl/call_return_ctrl_if.sv
// call_return_ctrl_if
//   Bundles the instruction-side inputs and the stack/PC/W/INTCON-side
//   outputs of call_return_ctrl.
//
//   Handshake: en is a one-clock strobe, issued once per instruction cycle.
//   There is no ready signal. instr and pc are sampled only on a clock where
//   en=1. The controller reports its own occupancy on busy, and any en it
//   receives while busy is consumed (FLUSH) or ignored (ISSUE). Every output
//   strobe (stk_en, stk_push, stk_pop, pc_load, w_load, gie_set) is high for
//   exactly one clock and is accepted unconditionally by its receiver.
//
//   Optional macro CALL_RETURN_CTRL_DEPTH_EN adds depth, ovf and unf.
//
//   modports
//     master : driven by the instruction/PC block and the stack (testbench)
//     slave  : the controller itself
interface call_return_ctrl_if #(
  parameter int PC_W = 10
);
  logic            en;
  logic [13:0]     instr;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] stk_top;
  logic            stk_en;
  logic            stk_push;
  logic            stk_pop;
  logic [PC_W-1:0] stk_data;
  logic            pc_load;
  logic [PC_W-1:0] pc_next;
  logic            w_load;
  logic [7:0]      w_data;
  logic            gie_set;
  logic            flush;
  logic            busy;
`ifdef CALL_RETURN_CTRL_DEPTH_EN
  logic [3:0]      depth;
  logic            ovf;
  logic            unf;

  modport master (
    output en, instr, pc, stk_top,
    input  stk_en, stk_push, stk_pop, stk_data, pc_load, pc_next,
           w_load, w_data, gie_set, flush, busy, depth, ovf, unf
  );
  modport slave (
    input  en, instr, pc, stk_top,
    output stk_en, stk_push, stk_pop, stk_data, pc_load, pc_next,
           w_load, w_data, gie_set, flush, busy, depth, ovf, unf
  );
`else
  modport master (
    output en, instr, pc, stk_top,
    input  stk_en, stk_push, stk_pop, stk_data, pc_load, pc_next,
           w_load, w_data, gie_set, flush, busy
  );
  modport slave (
    input  en, instr, pc, stk_top,
    output stk_en, stk_push, stk_pop, stk_data, pc_load, pc_next,
           w_load, w_data, gie_set, flush, busy
  );
`endif
endinterface

// File: rtl/call_return_ctrl.sv
// call_return_ctrl
//   Call/return sequencer for a PIC16F84-style core. Decodes CALL, GOTO,
//   RETURN, RETLW and RETFIE, drives the return-address stack push/pop,
//   loads the PC, and forces the second (NOP) instruction cycle.
//
//   Ports
//     clock     : system clock, rising edge
//     reset     : synchronous, active-low reset
//     bus       : call_return_ctrl_if.slave (instruction inputs, stack top,
//                 stack/PC/W/GIE strobes, flush, busy)
//     dbg_state : current FSM state (IDLE=0, ISSUE=1, FLUSH=2)
//
//   Macro CALL_RETURN_CTRL_DEPTH_EN adds a saturating depth counter with
//   sticky overflow/underflow flags (bus.depth, bus.ovf, bus.unf).
module call_return_ctrl #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  call_return_ctrl_if.slave      bus,
  output logic [1:0]             dbg_state
);

  // The depth counter is 4 bits wide.
  if (DEPTH < 1 || DEPTH > 15) begin : g_bad_depth
    $error("call_return_ctrl: DEPTH must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;

  localparam logic [13:0] OP_RETURN = 14'h0008;
  localparam logic [13:0] OP_RETFIE = 14'h0009;

  logic is_call, is_goto, is_retlw, is_return, is_retfie, is_pop;

  always_comb begin
    is_call   = (bus.instr[13:11] == 3'b100);
    is_goto   = (bus.instr[13:11] == 3'b101);
    is_retlw  = (bus.instr[13:10] == 4'b1101);
    is_return = (bus.instr == OP_RETURN);
    is_retfie = (bus.instr == OP_RETFIE);
    is_pop    = is_retlw | is_return | is_retfie;
  end

  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      bus.stk_en   <= 1'b0;
      bus.stk_push <= 1'b0;
      bus.stk_pop  <= 1'b0;
      bus.stk_data <= '0;
      bus.pc_load  <= 1'b0;
      bus.pc_next  <= '0;
      bus.w_load   <= 1'b0;
      bus.w_data   <= '0;
      bus.gie_set  <= 1'b0;
      bus.flush    <= 1'b0;
      bus.busy     <= 1'b0;
`ifdef CALL_RETURN_CTRL_DEPTH_EN
      bus.depth    <= '0;
      bus.ovf      <= 1'b0;
      bus.unf      <= 1'b0;
`endif
    end else begin
      // Strobes are high only in the clock following the decode edge.
      bus.stk_en   <= 1'b0;
      bus.stk_push <= 1'b0;
      bus.stk_pop  <= 1'b0;
      bus.pc_load  <= 1'b0;
      bus.w_load   <= 1'b0;
      bus.gie_set  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.en && (is_call || is_goto || is_pop)) begin
            state       <= ISSUE;
            bus.pc_load <= 1'b1;
            bus.flush   <= 1'b1;
            bus.busy    <= 1'b1;
            if (is_call) begin
              bus.stk_en   <= 1'b1;
              bus.stk_push <= 1'b1;
              // Return address wraps within PC_W bits.
              bus.stk_data <= bus.pc + PC_W'(1);
              bus.pc_next  <= bus.instr[PC_W-1:0];
`ifdef CALL_RETURN_CTRL_DEPTH_EN
              if (bus.depth == 4'(DEPTH)) bus.ovf <= 1'b1;
              else                        bus.depth <= bus.depth + 4'd1;
`endif
            end else if (is_goto) begin
              bus.pc_next <= bus.instr[PC_W-1:0];
            end else begin
              // stk_top is taken before the pop moves the stack.
              bus.stk_en  <= 1'b1;
              bus.stk_pop <= 1'b1;
              bus.pc_next <= bus.stk_top;
              if (is_retfie) bus.gie_set <= 1'b1;
              if (is_retlw) begin
                bus.w_load <= 1'b1;
                bus.w_data <= bus.instr[7:0];
              end
`ifdef CALL_RETURN_CTRL_DEPTH_EN
              if (bus.depth == 4'd0) bus.unf <= 1'b1;
              else                   bus.depth <= bus.depth - 4'd1;
`endif
            end
          end
        end

        ISSUE: begin
          // Any en seen here is ignored; the NOP cycle is the next en.
          state <= FLUSH;
        end

        FLUSH: begin
          if (bus.en) begin
            state     <= IDLE;
            bus.flush <= 1'b0;
            bus.busy  <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          bus.flush <= 1'b0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_call_return_ctrl.sv
// tb_call_return_ctrl
//   Directed, table-driven bench for call_return_ctrl. Each table row is one
//   clock: inputs applied before the rising edge, outputs compared 1 ns after.
module tb_call_return_ctrl;

  localparam int PC_W = 10;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  call_return_ctrl_if #(.PC_W(PC_W)) bus ();

  call_return_ctrl #(.PC_W(PC_W), .DEPTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- vector table ----------------
  // Output bundle: {stk_en, push, pop, stk_data, pc_load, pc_next,
  //                 w_load, w_data, gie_set, flush, busy}
  localparam int OW = 3 + PC_W + 1 + PC_W + 1 + 8 + 3;

  typedef struct {
    logic            rst_n;
    logic            en;
    logic [13:0]     instr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] top;
    logic [OW-1:0]   exp;
  } vec_t;

  vec_t vecs[$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [OW-1:0] outs(
    input logic sen, input logic psh, input logic pop,
    input logic [PC_W-1:0] sdata, input logic pcl, input logic [PC_W-1:0] pcn,
    input logic wl, input logic [7:0] wd, input logic gie,
    input logic fl, input logic bsy);
    return {sen, psh, pop, sdata, pcl, pcn, wl, wd, gie, fl, bsy};
  endfunction

  task automatic add(input logic r, input logic e, input logic [13:0] i,
                     input logic [PC_W-1:0] p, input logic [PC_W-1:0] t,
                     input logic [OW-1:0] x);
    vec_t v;
    v.rst_n = r; v.en = e; v.instr = i; v.pc = p; v.top = t; v.exp = x;
    vecs.push_back(v);
  endtask

  function automatic logic [OW-1:0] actual();
    return {bus.stk_en, bus.stk_push, bus.stk_pop, bus.stk_data, bus.pc_load,
            bus.pc_next, bus.w_load, bus.w_data, bus.gie_set, bus.flush,
            bus.busy};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic e, input logic [13:0] i,
                       input logic [PC_W-1:0] p, input logic [PC_W-1:0] t);
    @(negedge clock);
    reset       = r;
    bus.en      = e;
    bus.instr   = i;
    bus.pc      = p;
    bus.stk_top = t;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef CALL_RETURN_CTRL_DEPTH_EN
  task automatic check_depth(input string name, input logic [3:0] d,
                             input logic o, input logic u);
    n_vec++;
    if (bus.depth !== d || bus.ovf !== o || bus.unf !== u) begin
      n_bad++;
      $display("FAIL %s: got depth=%0d ovf=%b unf=%b expected depth=%0d ovf=%b unf=%b",
               name, bus.depth, bus.ovf, bus.unf, d, o, u);
    end
  endtask

  // One full instruction: decode clock, gap, NOP en clock, gap.
  task automatic run_instr(input logic [13:0] i, input logic [PC_W-1:0] p);
    drive(1'b1, 1'b1, i, p, 10'h000);
    drive(1'b1, 1'b0, i, p, 10'h000);
    drive(1'b1, 1'b1, 14'h0000, p, 10'h000);
    drive(1'b1, 1'b0, 14'h0000, p, 10'h000);
  endtask
`endif

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    reset = 1'b0; bus.en = 1'b0; bus.instr = '0; bus.pc = '0; bus.stk_top = '0;

    // Reset held 3 clocks with a CALL presented: nothing happens.
    add(0, 1, 14'h2155, 10'h0A3, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h00,0,0,0));
    add(0, 1, 14'h2155, 10'h0A3, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h00,0,0,0));
    add(0, 1, 14'h2155, 10'h0A3, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h00,0,0,0));
    // CALL 0x155 at pc 0x0A3.
    add(1, 1, 14'h2155, 10'h0A3, 10'h000, outs(1,1,0,10'h0A4,1,10'h155,0,8'h00,0,1,1));
    add(1, 0, 14'h2155, 10'h0A3, 10'h000, outs(0,0,0,10'h0A4,0,10'h155,0,8'h00,0,1,1));
    // NOP cycle: RETURN word is ignored.
    add(1, 1, 14'h0008, 10'h155, 10'h0A4, outs(0,0,0,10'h0A4,0,10'h155,0,8'h00,0,0,0));
    add(1, 0, 14'h0008, 10'h155, 10'h0A4, outs(0,0,0,10'h0A4,0,10'h155,0,8'h00,0,0,0));
    // RETLW 0x42 with stk_top 0x0A4.
    add(1, 1, 14'h3442, 10'h155, 10'h0A4, outs(1,0,1,10'h0A4,1,10'h0A4,1,8'h42,0,1,1));
    add(1, 0, 14'h3442, 10'h155, 10'h0A4, outs(0,0,0,10'h0A4,0,10'h0A4,0,8'h42,0,1,1));
    add(1, 1, 14'h2155, 10'h0A4, 10'h0A4, outs(0,0,0,10'h0A4,0,10'h0A4,0,8'h42,0,0,0));
    add(1, 0, 14'h2155, 10'h0A4, 10'h0A4, outs(0,0,0,10'h0A4,0,10'h0A4,0,8'h42,0,0,0));
    // CALL 0x200 at pc 0x3FF: return address wraps to 0.
    add(1, 1, 14'h2200, 10'h3FF, 10'h0A4, outs(1,1,0,10'h000,1,10'h200,0,8'h42,0,1,1));
    add(1, 0, 14'h2200, 10'h3FF, 10'h0A4, outs(0,0,0,10'h000,0,10'h200,0,8'h42,0,1,1));
    add(1, 1, 14'h0009, 10'h200, 10'h000, outs(0,0,0,10'h000,0,10'h200,0,8'h42,0,0,0));
    add(1, 0, 14'h0009, 10'h200, 10'h000, outs(0,0,0,10'h000,0,10'h200,0,8'h42,0,0,0));
    // RETFIE with stk_top 0.
    add(1, 1, 14'h0009, 10'h200, 10'h000, outs(1,0,1,10'h000,1,10'h000,0,8'h42,1,1,1));
    add(1, 0, 14'h0009, 10'h200, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h42,0,1,1));
    add(1, 1, 14'h0000, 10'h000, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h42,0,0,0));
    add(1, 0, 14'h0000, 10'h000, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h42,0,0,0));
    // GOTO 0x3FF: no stack access.
    add(1, 1, 14'h2BFF, 10'h001, 10'h000, outs(0,0,0,10'h000,1,10'h3FF,0,8'h42,0,1,1));
    add(1, 0, 14'h2BFF, 10'h001, 10'h000, outs(0,0,0,10'h000,0,10'h3FF,0,8'h42,0,1,1));
    // Reset during FLUSH clears everything.
    add(0, 0, 14'h0000, 10'h3FF, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h00,0,0,0));
    add(1, 0, 14'h0000, 10'h3FF, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h00,0,0,0));
    // RETURN afterwards decodes normally.
    add(1, 1, 14'h0008, 10'h3FF, 10'h123, outs(1,0,1,10'h000,1,10'h123,0,8'h00,0,1,1));
    add(1, 0, 14'h0008, 10'h3FF, 10'h123, outs(0,0,0,10'h000,0,10'h123,0,8'h00,0,1,1));
    add(1, 1, 14'h0000, 10'h123, 10'h000, outs(0,0,0,10'h000,0,10'h123,0,8'h00,0,0,0));
    add(1, 0, 14'h0000, 10'h123, 10'h000, outs(0,0,0,10'h000,0,10'h123,0,8'h00,0,0,0));
    // MOVLW (opcode 1100) is not RETLW: no action.
    add(1, 1, 14'h3042, 10'h124, 10'h000, outs(0,0,0,10'h000,0,10'h123,0,8'h00,0,0,0));
    add(1, 0, 14'h3042, 10'h124, 10'h000, outs(0,0,0,10'h000,0,10'h123,0,8'h00,0,0,0));
    // Reset mid-ISSUE: no strobe after the reset edge.
    add(1, 1, 14'h2155, 10'h0A3, 10'h000, outs(1,1,0,10'h0A4,1,10'h155,0,8'h00,0,1,1));
    add(0, 0, 14'h0000, 10'h0A3, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h00,0,0,0));
    add(1, 0, 14'h0000, 10'h0A3, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h00,0,0,0));
    add(1, 1, 14'h0000, 10'h0A3, 10'h000, outs(0,0,0,10'h000,0,10'h000,0,8'h00,0,0,0));

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].en, vecs[k].instr, vecs[k].pc, vecs[k].top);
      check($sformatf("vec%0d", k), actual(), vecs[k].exp);
    end

`ifdef CALL_RETURN_CTRL_DEPTH_EN
    drive(1'b0, 1'b0, 14'h0000, 10'h000, 10'h000);
    drive(1'b1, 1'b0, 14'h0000, 10'h000, 10'h000);
    check_depth("depth_reset", 4'd0, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) run_instr(14'h2100, 10'(c));
    check_depth("depth_8_calls", 4'd8, 1'b0, 1'b0);
    run_instr(14'h2100, 10'h010);
    check_depth("depth_9_calls", 4'd8, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) run_instr(14'h0008, 10'h100);
    check_depth("depth_8_returns", 4'd0, 1'b1, 1'b0);
    run_instr(14'h0008, 10'h100);
    check_depth("depth_9_returns", 4'd0, 1'b1, 1'b1);
    run_instr(14'h2100, 10'h000);
    check_depth("depth_sticky", 4'd1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 14'h0000, 10'h000, 10'h000);
    check_depth("depth_clear", 4'd0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/call_return_ctrl.md
# call_return_ctrl

Call/return sequencer for the PIC16F84 core. It decodes CALL, GOTO, RETURN, RETLW and RETFIE from the current instruction word. For each one it drives the push/pop side of the 8-level hardware return-address stack, loads the program counter, and forces the mandatory second NOP instruction cycle. It sits between the instruction register/PC block and the stack, acting as the sole initiator of stack push/pop requests.

## Interface
Parameters:
- PC_W, 10, program counter and stack entry width
- DEPTH, 8, stack levels tracked by the depth counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- en  in  1  instruction-cycle strobe, one clock wide, once per instruction cycle
- instr  in  14  instruction word of the current cycle, valid while en=1
- pc  in  PC_W  address of the current instruction, valid while en=1
- stk_top  in  PC_W  stack top-of-stack output
- stk_en  out  1  stack enable
- stk_push  out  1  push request, presented with stk_en
- stk_pop  out  1  pop request, presented with stk_en
- stk_data  out  PC_W  return address to push
- pc_load  out  1  one-clock PC load strobe
- pc_next  out  PC_W  PC load value
- w_load  out  1  one-clock W-register load strobe (RETLW)
- w_data  out  8  RETLW literal
- gie_set  out  1  one-clock strobe to set INTCON.GIE (RETFIE)
- flush  out  1  high for the whole forced-NOP instruction cycle
- busy  out  1  high from the decode clock until the forced-NOP cycle ends

## Operation
Decode happens only when en=1 and state=IDLE:
- CALL (instr[13:11]=3'b100): push pc+1; pc_next=instr[PC_W-1:0]
- GOTO (3'b101): no stack access; pc_next=instr[PC_W-1:0]
- RETURN (14'h0008): pop; pc_next=stk_top
- RETFIE (14'h0009): pop; pc_next=stk_top; gie_set=1
- RETLW (instr[13:10]=4'b1101): pop; pc_next=stk_top; w_load=1; w_data=instr[7:0]
- All other words: no action, state stays IDLE.

Rules:
- The return address pc+1 is PC_W wide and wraps: 0x3FF+1 gives 0x000.
- stk_top is sampled at the decode clock, before the pop takes effect. The stack's top moves one clock later.
- stk_push and stk_pop are never high together. stk_en is high exactly when either one is high.

State machine: IDLE, ISSUE, FLUSH.
- IDLE -> ISSUE on a recognized instruction with en=1.
- ISSUE: lasts exactly one clock. All strobes (stk_en/push/pop, pc_load, w_load, gie_set) are high for this clock only. Then -> FLUSH.
- FLUSH: flush=1. The next en pulse is consumed as the NOP cycle and its instr is ignored. On that en -> IDLE.
- An instruction presented while in ISSUE or FLUSH is ignored.

Reset (active-low, synchronous):
- state=IDLE
- All outputs 0, including stk_data, pc_next and w_data.
- Applies mid-ISSUE or mid-FLUSH as well; no strobe is emitted after the reset edge.

## Timing
- Decode edge (en=1, IDLE) registers the outputs; the strobes are visible on the following clock, a latency of 1 clock.
- flush and busy go high together with the strobes.
- busy falls one clock after the consuming en of the FLUSH cycle, in the same clock that flush falls.
- Minimum spacing between en pulses is 2 clocks. A back-to-back en is a caller error; behaviour is defined only as "ignored while busy".
- stk_data and pc_next hold their value after ISSUE until the next ISSUE.

## Configuration
Macro: CALL_RETURN_CTRL_DEPTH_EN.

Defined adds:
- Output depth[3:0]: reset 0. +1 per push, saturating at DEPTH. −1 per pop, saturating at 0.
- Output ovf: sticky, set on a push while depth=DEPTH.
- Output unf: sticky, set on a pop while depth=0.
- ovf and unf clear only on reset.
- Push and pop still proceed normally. The stack silently drops its oldest entry on overflow and returns 0 on underflow.

Undefined:
- The ports depth, ovf and unf do not exist. No counter logic is present.

## Test plan
- Reset: hold reset=0 for 3 clocks with en=1 and instr=CALL 0x155 -> all outputs 0, busy=0, no strobes.
- CALL: pc=0x0A3, instr=14'h2155 -> ISSUE clock has stk_push=1, stk_data=0x0A4, pc_load=1, pc_next=0x155. Next en -> flush=1, instr ignored. Then busy=0.
- RETLW: stk_top=0x0A4, instr=14'h3442 -> stk_pop=1, pc_next=0x0A4, w_load=1, w_data=0x42, gie_set=0.
- Wrap and RETFIE: CALL at pc=0x3FF -> stk_data=0x000. Then RETFIE with stk_top=0x000 -> pc_next=0x000, gie_set=1, stk_pop=1.
- Reset during FLUSH: reset=0 while flush=1 -> next clock state=IDLE, flush=0. A following RETURN decodes normally.
- With the macro defined: 9 CALLs -> depth=8, ovf=1. 9 RETURNs -> depth=0, unf=1. Both flags stay set until reset.
